// File: rtl/imem_loader.sv
// imem_loader: streams a byte-serial program image into an instruction memory.
//
// Stream format: 16-bit little-endian word count N (1..DEPTH), then 4*N bytes
// assembled little-endian into 32-bit words written at consecutive word
// addresses. The CPU is held in reset (o_cpu_hold) until a load completes.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to append a one-byte XOR
// checksum of all data bytes after the last word; a mismatch ends in ERR.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_start      one-cycle load request (honoured in IDLE, DONE, ERR)
//   i_rx_data    incoming byte
//   i_rx_valid   i_rx_data is valid
//   o_rx_ready   loader accepts a byte this cycle
//   o_mem_we     memory write strobe (one cycle per word)
//   o_mem_addr   word-aligned byte address of the write
//   o_mem_wdata  write data word
//   o_busy       load in progress
//   o_done       load finished successfully
//   o_error      load aborted (bad length or checksum)
//   o_cpu_hold   CPU hold request, low only in DONE
module imem_loader #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic        o_cpu_hold
);

    typedef enum logic [2:0] {
        StIdle,
        StLen0,
        StLen1,
        StData,
        StWrite,
`ifdef IMEM_LOADER_CHECKSUM_EN
        StCsum,
`endif
        StDone,
        StErr
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [15:0] r_len;
    logic [15:0] r_word_idx;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_word;       // first three bytes of the word in progress
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    logic        w_accept;
    logic [15:0] w_len_full;
    logic        w_len_bad;
    logic        w_last_word;

    assign w_accept    = i_rx_valid && o_rx_ready;
    assign w_len_full  = {i_rx_data, r_len[7:0]};
    assign w_len_bad   = (w_len_full == 16'd0) || (32'(w_len_full) > DEPTH);
    assign w_last_word = ((r_word_idx + 16'd1) == r_len);

    always_comb begin
        w_state_next = r_state;
        o_rx_ready   = 1'b0;
        o_busy       = 1'b0;
        o_mem_we     = 1'b0;
        o_done       = 1'b0;
        o_error      = 1'b0;
        o_cpu_hold   = 1'b1;
        unique case (r_state)
            StIdle, StDone, StErr: begin
                o_done     = (r_state == StDone);
                o_error    = (r_state == StErr);
                o_cpu_hold = (r_state != StDone);
                if (i_start) w_state_next = StLen0;
            end
            StLen0: begin
                o_rx_ready = 1'b1;
                o_busy     = 1'b1;
                if (w_accept) w_state_next = StLen1;
            end
            StLen1: begin
                o_rx_ready = 1'b1;
                o_busy     = 1'b1;
                if (w_accept) w_state_next = w_len_bad ? StErr : StData;
            end
            StData: begin
                o_rx_ready = 1'b1;
                o_busy     = 1'b1;
                if (w_accept && (r_byte_cnt == 2'd3)) w_state_next = StWrite;
            end
            StWrite: begin
                o_busy   = 1'b1;
                o_mem_we = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                w_state_next = w_last_word ? StCsum : StData;
`else
                w_state_next = w_last_word ? StDone : StData;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            StCsum: begin
                o_rx_ready = 1'b1;
                o_busy     = 1'b1;
                if (w_accept) w_state_next = (i_rx_data == r_csum) ? StDone : StErr;
            end
`endif
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_len       <= 16'd0;
            r_word_idx  <= 16'd0;
            r_byte_cnt  <= 2'd0;
            r_word      <= 24'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum      <= 8'd0;
`endif
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle, StDone, StErr: begin
                    if (i_start) begin
                        r_word_idx <= 16'd0;
                        r_byte_cnt <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum     <= 8'd0;
`endif
                    end
                end
                StLen0: if (w_accept) r_len[7:0] <= i_rx_data;
                StLen1: if (w_accept) r_len[15:8] <= i_rx_data;
                StData: begin
                    if (w_accept) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum     <= r_csum ^ i_rx_data;
`endif
                        if (r_byte_cnt == 2'd3) begin
                            // Capture address/data here so they are stable during WRITE
                            // and hold afterwards.
                            r_mem_addr  <= {14'd0, r_word_idx, 2'b00};
                            r_mem_wdata <= {i_rx_data, r_word};
                        end else begin
                            // Shift in from the top: after three bytes r_word = {b2, b1, b0}.
                            r_word <= {i_rx_data, r_word[23:8]};
                        end
                    end
                end
                StWrite: r_word_idx <= r_word_idx + 16'd1;
                default: ;
            endcase
        end
    end

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader. Stimulus tasks push expected
// memory writes into a queue; an independent monitor pops and compares on every
// o_mem_we pulse. Checksum cases are included when IMEM_LOADER_CHECKSUM_EN is set.
module tb_imem_loader;

    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_e;
    logic [31:0] tb_addr;
    logic [7:0]  tb_csum;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .o_rx_ready  (rx_ready),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_busy      (busy),
        .o_done      (done),
        .o_error     (error),
        .o_cpu_hold  (cpu_hold)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected none",
                         mem_addr, mem_wdata);
            end else begin
                exp_e = exp_q.pop_front();
                check("write_addr", mem_addr, exp_e[63:32]);
                check("write_data", mem_wdata, exp_e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        bit taken = 1'b0;
        if (stall) begin
            rx_valid = 1'b0;
            step();
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 50 && !taken; i++) begin
            @(negedge clk);
            if (rx_ready) begin
                step();
                taken = 1'b1;
            end
        end
        rx_valid = 1'b0;
        if (!taken) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_accept_timeout: byte 0x%02h not accepted, expected accept", b);
        end
    endtask

    task automatic send_data_byte(input logic [7:0] b, input bit stall);
        tb_csum = tb_csum ^ b;
        send_byte(b, stall);
    endtask

    task automatic send_word(input logic [31:0] w, input bit stall);
        exp_q.push_back({tb_addr, w});
        tb_addr = tb_addr + 32'd4;
        for (int k = 0; k < 4; k++) send_data_byte(w[8*k +: 8], stall);
    endtask

    task automatic send_header(input logic [15:0] n, input bit stall);
        tb_addr = 32'd0;
        tb_csum = 8'd0;
        send_byte(n[7:0], stall);
        send_byte(n[15:8], stall);
    endtask

    task automatic wait_end();
        for (int i = 0; i < 20 && !(done || error); i++) step();
    endtask

    task automatic finish_load(input string tag);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(tb_csum, 1'b0);
`endif
        wait_end();
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        tb_addr  = 32'd0;
        tb_csum  = 8'd0;
        step();
        step();
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // IDLE ignores incoming bytes.
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        step();
        check("idle_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        rx_valid = 1'b0;

        // N=1, word 0x12345678 at address 0.
        pulse_start();
        check("len0_busy", {31'd0, busy}, 32'd1);
        check("len0_rx_ready", {31'd0, rx_ready}, 32'd1);
        send_header(16'd1, 1'b0);
        send_word(32'h1234_5678, 1'b0);
        finish_load("n1");
        check("n1_wdata_hold", mem_wdata, 32'h1234_5678);
        check("n1_we_low", {31'd0, mem_we}, 32'd0);

        // Start in DONE restarts; N=3 with rx_valid toggling.
        pulse_start();
        check("restart_busy", {31'd0, busy}, 32'd1);
        check("restart_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("restart_done", {31'd0, done}, 32'd0);
        send_header(16'd3, 1'b1);
        send_word(32'hDEAD_BEEF, 1'b1);
        send_word(32'h0102_0304, 1'b1);
        send_word(32'hA5A5_5A5A, 1'b1);
        finish_load("n3");
        check("n3_addr_hold", mem_addr, 32'h0000_0008);

        // N=0 header.
        pulse_start();
        send_header(16'd0, 1'b0);
        wait_end();
        check("n0_error", {31'd0, error}, 32'd1);
        check("n0_done", {31'd0, done}, 32'd0);
        check("n0_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        pulse_start();
        check("err_restart_busy", {31'd0, busy}, 32'd1);
        check("err_restart_error", {31'd0, error}, 32'd0);

        // N=1025 > DEPTH.
        send_header(16'd1025, 1'b0);
        wait_end();
        check("n1025_error", {31'd0, error}, 32'd1);
        check("n1025_cpu_hold", {31'd0, cpu_hold}, 32'd1);

        // N=DEPTH is legal: header must reach DATA.
        pulse_start();
        send_header(16'd1024, 1'b0);
        check("n1024_busy", {31'd0, busy}, 32'd1);
        check("n1024_rx_ready", {31'd0, rx_ready}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // Start pulsed mid-DATA is ignored.
        pulse_start();
        send_header(16'd1, 1'b0);
        exp_q.push_back({32'd0, 32'hCAFE_F00D});
        send_data_byte(8'h0D, 1'b0);
        send_data_byte(8'hF0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_in_data_busy", {31'd0, busy}, 32'd1);
        send_data_byte(8'hFE, 1'b0);
        send_data_byte(8'hCA, 1'b0);
        finish_load("start_ign");

        // Reset after two data bytes: no write, reset outputs.
        pulse_start();
        send_header(16'd1, 1'b0);
        send_data_byte(8'h11, 1'b0);
        send_data_byte(8'h22, 1'b0);
        rst_n = 1'b0;
        step();
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        repeat (5) step();
        check("midrst_idle", {31'd0, busy}, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // AA^BB^CC^DD = 0x00.
        pulse_start();
        send_header(16'd1, 1'b0);
        send_word(32'hDDCC_BBAA, 1'b0);
        send_byte(8'h00, 1'b0);
        wait_end();
        check("csum_ok_done", {31'd0, done}, 32'd1);
        check("csum_ok_error", {31'd0, error}, 32'd0);
        pulse_start();
        send_header(16'd1, 1'b0);
        send_word(32'hDDCC_BBAA, 1'b0);
        send_byte(8'h01, 1'b0);
        wait_end();
        check("csum_bad_error", {31'd0, error}, 32'd1);
        check("csum_bad_done", {31'd0, done}, 32'd0);
`endif

        repeat (3) step();
        check("writes_outstanding", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 1024, SHALL set the instruction-memory capacity in 32-bit words.
REQ-002 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 start  input  1  SHALL be a one-cycle request to begin a load; it is honoured only in IDLE, DONE or ERR.
REQ-005 rx_data  input  8  SHALL be the incoming byte.
REQ-006 rx_valid  input  1  SHALL indicate that rx_data is valid.
REQ-007 rx_ready  output  1  SHALL indicate that the loader accepts a byte this cycle.
REQ-008 mem_we  output  1  SHALL be the write strobe to the instruction-memory write port.
REQ-009 mem_addr  output  32  SHALL be the byte address; it is always word aligned, with bits [1:0] = 0.
REQ-010 mem_wdata  output  32  SHALL be the write data word.
REQ-011 busy  output  1  SHALL be high in LEN0, LEN1, DATA, WRITE and CSUM.
REQ-012 done  output  1  SHALL be high only in DONE.
REQ-013 error  output  1  SHALL be high only in ERR.
REQ-014 cpu_hold  output  1  SHALL be high in every state except DONE.

Function
REQ-015 A byte SHALL be consumed exactly on cycles where rx_valid && rx_ready are both high.
REQ-016 rx_ready SHALL be 1 in LEN0, LEN1, DATA and CSUM, and 0 in all other states.
REQ-017 The states SHALL be IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE and ERR.
REQ-018 The transition IDLE/DONE/ERR -> LEN0 SHALL occur on start; on entry, the word index and byte count are cleared.
REQ-019 Stream format SHALL be: count N as 16-bit little-endian (LEN0 takes the low byte, LEN1 the high byte), then 4*N data bytes.
REQ-020 On the LEN1 byte, N = 0 or N > DEPTH SHALL go to ERR; otherwise the loader goes to DATA.
REQ-021 Word assembly SHALL be little-endian: byte k of a word (k = 0..3) lands in bits [8k+7:8k].
REQ-022 The 4th accepted byte of a word SHALL move DATA -> WRITE.
REQ-023 WRITE SHALL last exactly one cycle, with mem_we = 1, mem_addr = word_idx*4 and mem_wdata = the assembled word.
REQ-024 mem_we SHALL go high on the cycle after the 4th byte is accepted.
REQ-025 After WRITE, word_idx SHALL increment; if word_idx+1 == N the loader goes to CSUM (when configured) or DONE, otherwise back to DATA.
REQ-026 Outside WRITE, mem_we SHALL be 0; mem_addr and mem_wdata hold their last values.
REQ-027 word_idx SHALL be 16 bits wide and never wrap, because REQ-020 bounds N to DEPTH.
REQ-028 start SHALL be ignored while busy = 1.
REQ-029 rx_valid SHALL be ignored in IDLE, WRITE, DONE and ERR; no byte is consumed.
REQ-030 Stalls on rx_valid SHALL be allowed in any accepting state, with no timeout.
REQ-031 DONE and ERR SHALL hold until start or reset.

Reset
REQ-032 With rst_n = 0 at a rising clk edge, the loader SHALL enter IDLE.
REQ-033 Reset values SHALL be: rx_ready = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, busy = 0, done = 0, error = 0, cpu_hold = 1.
REQ-034 Reset mid-load SHALL abandon the partial word and issue no further writes; memory already written is not restored.

Configuration
REQ-035 Macro IMEM_LOADER_CHECKSUM_EN SHALL control the checksum feature as follows.
- Defined: a running XOR of all data bytes is kept; after the last WRITE the loader enters CSUM and accepts one byte; match -> DONE, mismatch -> ERR.
- Not defined: the CSUM state and checksum register are absent; the last WRITE goes directly to DONE.

Verification
REQ-036 Load with N=1, bytes 01 00 78 56 34 12 -> one mem_we pulse, addr 0x0, wdata 0x12345678, then done=1 and cpu_hold=0.
REQ-037 Load with N=3 and rx_valid toggling every other cycle -> three writes at addr 0x0, 0x4, 0x8, in order; no mem_we while stalled; done=1 after the 3rd write.
REQ-038 Header 00 00 (N=0) and header 01 04 (N=1025, DEPTH=1024) -> ERR with error=1, no mem_we, cpu_hold=1; a subsequent start re-enters LEN0.
REQ-039 With IMEM_LOADER_CHECKSUM_EN defined, N=1, data AA BB CC DD -> checksum 0x00 gives DONE; checksum 0x01 gives ERR.
REQ-040 rst_n=0 after 2 of the 4 data bytes -> IDLE next cycle, all outputs at reset values, no write.
REQ-041 start pulsed during DATA -> ignored, the load completes normally; start pulsed in DONE -> busy=1 and cpu_hold=1 on the next cycle.
